// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: word width, fetch FSM
// state encodings and the NOP encoding used as the idle value of iin.
package instruction_fetch_pkg;

    localparam int          IF_INSTR_W = 16;
    localparam logic [15:0] IF_NOP     = 16'h0000;

    typedef enum logic [1:0] {
        FS_IDLE    = 2'd0,
        FS_REQ     = 2'd1,
        FS_DISCARD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_fifo.sv
// Prefetch FIFO: DEPTH x WIDTH circular buffer with push/pop/flush.
// Exposes the head and the entry behind it so the consumer can present the
// next word in the same cycle as a pop. DEPTH must be a power of two.
module instruction_fetch_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 16,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_head,
    output logic [WIDTH-1:0] o_next,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    // A pop frees the slot in the same cycle, so push-while-full is legal with a pop.
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointer and occupancy update; flush wins over push/pop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_next  = r_mem[r_rd_ptr + PTR_W'(1)];
    assign o_count = r_count;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: program counter, req/ack memory fetch FSM and the registered
// iin/iin_valid view of the prefetch FIFO head. A PC load flushes everything;
// a request already on the bus is allowed to finish and its word is dropped.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter  int                ADDR_W   = 8,
    parameter  int                INSTR_W  = IF_INSTR_W,
    parameter  int                DEPTH    = 2,
    parameter  logic [ADDR_W-1:0] RESET_PC = '0,
    localparam int                CNT_W    = ((DEPTH > 1) ? $clog2(DEPTH) : 1) + 1
) (
    input  logic               clk,
    input  logic               resetn,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] iin,
    output logic               iin_valid,
    input  logic               instr_done,
    input  logic               pc_load,
    input  logic [ADDR_W-1:0]  pc_load_addr
);

    fetch_state_t       r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic               r_mem_req;
    logic [INSTR_W-1:0] r_iin;
    logic               r_iin_valid;

    logic [ADDR_W-1:0]  w_pc_inc;
    logic               w_push;
    logic               w_pop;
    logic               w_room;
    logic               w_full;
    logic               w_empty;
    logic [CNT_W-1:0]   w_count;
    logic [INSTR_W-1:0] w_head;
    logic [INSTR_W-1:0] w_next;

    assign w_pc_inc = r_pc + ADDR_W'(1);

    // Only a live (non-discarded) request pushes; a jump drops the word and any retire.
    assign w_push = (r_state == FS_REQ) && mem_ack && !pc_load;
    assign w_pop  = instr_done && r_iin_valid && !pc_load;

    // Room for another request once this cycle's push and pop have landed.
    always_comb begin
        w_room = 1'b0;
        case ({w_push, w_pop})
            2'b11:   w_room = !w_full;
            2'b10:   w_room = (w_count < CNT_W'(DEPTH - 1));
            2'b01:   w_room = 1'b1;
            default: w_room = !w_full;
        endcase
    end

    instruction_fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (pc_load),
        .i_wdata (mem_rdata),
        .o_head  (w_head),
        .o_next  (w_next),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Fetch FSM with registered mem_req/mem_addr; mem_addr only moves when no request is held.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= FS_IDLE;
            r_pc       <= RESET_PC;
            r_mem_req  <= 1'b0;
            r_mem_addr <= RESET_PC;
        end else if (pc_load) begin
            r_pc <= pc_load_addr;
            if (r_state != FS_IDLE && !mem_ack) begin
                // Bus request still pending: keep it up and swallow its reply.
                r_state <= FS_DISCARD;
            end else begin
                r_state    <= FS_IDLE;
                r_mem_req  <= 1'b0;
                r_mem_addr <= pc_load_addr;
            end
        end else begin
            case (r_state)
                FS_IDLE: begin
                    r_mem_addr <= r_pc;
                    if (w_room) begin
                        r_state   <= FS_REQ;
                        r_mem_req <= 1'b1;
                    end
                end
                FS_REQ: begin
                    if (mem_ack) begin
                        r_pc       <= w_pc_inc;
                        r_mem_addr <= w_pc_inc;
                        if (!w_room) begin
                            r_state   <= FS_IDLE;
                            r_mem_req <= 1'b0;
                        end
                    end
                end
                FS_DISCARD: begin
                    if (mem_ack) begin
                        r_state    <= FS_IDLE;
                        r_mem_req  <= 1'b0;
                        r_mem_addr <= r_pc;
                    end
                end
                default: begin
                    r_state   <= FS_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Present the FIFO head; on a pop, show the following entry at once if it exists.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_iin       <= INSTR_W'(IF_NOP);
            r_iin_valid <= 1'b0;
        end else if (pc_load) begin
            r_iin_valid <= 1'b0;
        end else if (w_pop) begin
            if (w_count >= CNT_W'(2)) begin
                r_iin       <= w_next;
                r_iin_valid <= 1'b1;
            end else begin
                r_iin_valid <= 1'b0;
            end
        end else if (!r_iin_valid && !w_empty) begin
            r_iin       <= w_head;
            r_iin_valid <= 1'b1;
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;
    assign iin       = r_iin;
    assign iin_valid = r_iin_valid;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus randomized traffic,
// checked against a transaction-level model of the instruction stream.
module tb_instruction_fetch;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;

    logic        mem_req, mem_ack, iin_valid, instr_done, pc_load;
    logic [7:0]  mem_addr, pc_load_addr;
    logic [15:0] mem_rdata, iin;

    logic        wr_req, wr_ack, wr_valid, wr_done;
    logic [7:0]  wr_addr;
    logic [15:0] wr_rdata, wr_iin;

    int          n_chk = 0;
    int          n_pass = 0;
    int          retired = 0;

    logic [15:0] q[$];
    logic [7:0]  mpc;
    bit          discard;
    logic [7:0]  wq[$];

    always #5 clk = ~clk;

    instruction_fetch #(.ADDR_W(8), .INSTR_W(16), .DEPTH(DEPTH), .RESET_PC(8'h00)) dut (
        .clk(clk), .resetn(resetn), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .iin(iin), .iin_valid(iin_valid),
        .instr_done(instr_done), .pc_load(pc_load), .pc_load_addr(pc_load_addr)
    );

    instruction_fetch #(.ADDR_W(8), .INSTR_W(16), .DEPTH(DEPTH), .RESET_PC(8'hFE)) dut_wrap (
        .clk(clk), .resetn(resetn), .mem_req(wr_req), .mem_addr(wr_addr),
        .mem_ack(wr_ack), .mem_rdata(wr_rdata), .iin(wr_iin), .iin_valid(wr_valid),
        .instr_done(wr_done), .pc_load(1'b0), .pc_load_addr(8'h00)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [15:0] word(input logic [7:0] a);
        return 16'h1000 + {8'h00, a};
    endfunction

    // One clock: drive inputs, advance the stream model, then check after the edge.
    task automatic step(input bit ack, input bit done, input bit load, input logic [7:0] tgt);
        logic       req0, v0;
        logic [7:0] addr0;
        logic [15:0] iin0;
        req0 = mem_req; addr0 = mem_addr; v0 = iin_valid; iin0 = iin;
        mem_ack      = ack && req0;
        mem_rdata    = (ack && req0) ? word(addr0) : 16'h0000;
        instr_done   = done;
        pc_load      = load;
        pc_load_addr = tgt;
        wr_ack   = wr_req;
        wr_rdata = word(wr_addr);
        wr_done  = wr_valid;
        if (wr_req) wq.push_back(wr_addr);

        if (load) begin
            q.delete();
            mpc = tgt;
            discard = req0 && !ack;
        end else begin
            if (done && v0) begin
                if (q.size() == 0) chk("retire_nonempty", 0, 1);
                else begin
                    chk("retire_word", iin0, q[0]);
                    void'(q.pop_front());
                    retired++;
                end
            end
            if (ack && req0) begin
                if (discard) discard = 0;
                else begin
                    chk("fetch_addr", addr0, mpc);
                    q.push_back(word(addr0));
                    mpc++;
                end
            end
        end

        @(posedge clk); #1;

        chk("occupancy", (q.size() + int'(mem_req)) <= DEPTH, 1);
        if (iin_valid) begin
            if (q.size() == 0) chk("valid_nonempty", 0, 1);
            else chk("head_word", iin, q[0]);
        end
        if (load) chk("flush_valid", iin_valid, 0);
        if (req0 && !ack) chk("req_hold", {mem_req, mem_addr}, {1'b1, addr0});
    endtask

    initial begin
        logic [7:0] wexp[4];
        int         r0;
        wexp = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        mem_ack = 0; mem_rdata = 0; instr_done = 0; pc_load = 0; pc_load_addr = 0;
        wr_ack = 0; wr_rdata = 0; wr_done = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 8'h00);
        chk("rst_valid", iin_valid, 0);
        chk("rst_iin", iin, 16'h0000);
        resetn = 1'b1;
        mpc = 8'h00; discard = 0; q.delete();

        // First fetch latency; instr_done while nothing is valid must be ignored.
        step(0, 1, 0, 0);
        chk("req_rise", mem_req, 1);
        chk("req_addr0", mem_addr, 8'h00);
        step(1, 0, 0, 0);
        chk("lat_early", iin_valid, 0);
        step(0, 0, 0, 0);
        chk("lat_valid", iin_valid, 1);
        chk("lat_iin", iin, 16'h1000);

        // Streaming: ack every cycle, retire every 4 cycles.
        r0 = retired;
        for (int c = 0; c < 200; c++) begin
            if (c % 4 == 3 && c > 8) chk("stream_valid", iin_valid, 1);
            step(1, (c % 4 == 3), 0, 0);
        end
        chk("stream_count", retired - r0, 50);

        // Jump while a request is outstanding, reply delayed 3 cycles.
        for (int k = 0; k < 10 && !mem_req; k++) step(0, 1, 0, 0);
        chk("t4_req_up", mem_req, 1);
        step(0, 0, 1, 8'h40);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("t4_idle", mem_req, 0);
        chk("t4_addr", mem_addr, 8'h40);
        for (int k = 0; k < 10 && !iin_valid; k++) step(1, 0, 0, 0);
        chk("t4_iin", iin, 16'h1040);

        // Jump in the same cycle as mem_ack and instr_done.
        for (int k = 0; k < 20 && !(mem_req && iin_valid); k++) step(1, 1, 0, 0);
        chk("t5_setup", mem_req && iin_valid, 1);
        step(1, 1, 1, 8'h80);
        chk("t5_valid", iin_valid, 0);
        chk("t5_req", mem_req, 0);
        chk("t5_addr", mem_addr, 8'h80);
        for (int k = 0; k < 10 && !iin_valid; k++) step(1, 0, 0, 0);
        chk("t5_iin", iin, 16'h1080);

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            step(1'($urandom_range(0, 1)), ($urandom % 3) == 0,
                 ($urandom % 40) == 0, 8'($urandom));
        end
        r0 = retired;
        for (int c = 0; c < 30; c++) step(1, 1, 0, 0);
        chk("drain_progress", retired > r0, 1);

        // Reset in the middle of a fetch.
        for (int k = 0; k < 20 && !(mem_req && iin_valid); k++) step(1, 1, 0, 0);
        chk("t1_setup", mem_req && iin_valid, 1);
        resetn = 1'b0;
        #1;
        chk("t1_req", mem_req, 0);
        chk("t1_addr", mem_addr, 8'h00);
        chk("t1_valid", iin_valid, 0);
        chk("t1_iin", iin, 16'h0000);

        for (int i = 0; i < 4; i++)
            chk("wrap_addr", (i < wq.size()) ? {24'h0, wq[i]} : 32'hFFFF_FFFF, {24'h0, wexp[i]});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
